// File: rtl/cpu_pkg.sv
// cpu_pkg: shared MIPS core constants (exception codes, reset/handler PCs, nop encoding)
package cpu_pkg;
    localparam int          EXC_W      = 5;
    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_INT    = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;
    localparam logic [4:0]  EXC_ADES   = 5'd5;
    localparam logic [4:0]  EXC_RI     = 5'd10;
    localparam logic [4:0]  EXC_OV     = 5'd12;
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] NOP        = 32'h0000_0000;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream inputs, control and registered outputs of one pipeline register
interface pipe_stage_reg_if #(
    parameter int PAYLOAD_W   = 69,
    parameter int EXC_W       = 5,
    parameter int STALL_CNT_W = 8
);
    logic                   en, flush, req;
    logic [31:0]            instr_i, pc_i;
    logic                   bd_i;
    logic [EXC_W-1:0]       exc_i, exc_new_i;
    logic [PAYLOAD_W-1:0]   payload_i;
    logic [31:0]            instr_o, pc_o;
    logic                   bd_o, valid_o;
    logic [EXC_W-1:0]       exc_o;
    logic [PAYLOAD_W-1:0]   payload_o;
    logic [STALL_CNT_W-1:0] stall_cnt_o;
    modport master (
        output en, flush, req, instr_i, pc_i, bd_i, exc_i, exc_new_i, payload_i,
        input  instr_o, pc_o, bd_o, valid_o, exc_o, payload_o, stall_cnt_o
    );
    modport slave (
        input  en, flush, req, instr_i, pc_i, bd_i, exc_i, exc_new_i, payload_i,
        output instr_o, pc_o, bd_o, valid_o, exc_o, payload_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk)
        if (clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage register with stall hold, bubble/exception flush and stall counter
module pipe_stage_reg #(
    parameter int          PAYLOAD_W        = 69,
    parameter int          EXC_W            = cpu_pkg::EXC_W,
    parameter logic [31:0] RESET_PC         = cpu_pkg::RESET_PC,
    parameter logic [31:0] HANDLER_PC       = cpu_pkg::HANDLER_PC,
    parameter bit          KEEP_PC_ON_FLUSH = 1'b1,
    parameter int          STALL_CNT_W      = 8
) (
    input logic             clk,
    input logic             reset,
    pipe_stage_reg_if.slave bus
);
    always_ff @(posedge clk)
        if (reset || bus.req) begin
            bus.instr_o   <= cpu_pkg::NOP;
            bus.payload_o <= '0;
            bus.exc_o     <= '0;
            bus.bd_o      <= 1'b0;
            bus.valid_o   <= 1'b0;
            bus.pc_o      <= reset ? RESET_PC : HANDLER_PC;
        end else if (bus.flush) begin
            bus.instr_o   <= cpu_pkg::NOP;
            bus.payload_o <= '0;
            bus.exc_o     <= '0;
            bus.valid_o   <= 1'b0;
            // keeping the PC lets a bubble ahead of a stalled instruction still report a correct EPC
            bus.pc_o      <= KEEP_PC_ON_FLUSH ? bus.pc_i : RESET_PC;
            bus.bd_o      <= KEEP_PC_ON_FLUSH ? bus.bd_i : 1'b0;
        end else if (bus.en) begin
            bus.instr_o   <= bus.instr_i;
            bus.pc_o      <= bus.pc_i;
            bus.bd_o      <= bus.bd_i;
            bus.payload_o <= bus.payload_i;
            bus.valid_o   <= 1'b1;
            bus.exc_o     <= (bus.exc_i != '0) ? bus.exc_i : bus.exc_new_i;
        end
    sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (reset | bus.req | bus.flush | bus.en),
        .inc (1'b1),
        .cnt (bus.stall_cnt_o)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: checks both PC-on-flush variants against a behavioural model every cycle
module tb_pipe_stage_reg;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [68:0] payload;
        logic        valid;
        logic [7:0]  cnt;
    } st_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic        en = 1'b0, flush = 1'b0, req = 1'b0, bd = 1'b0;
    logic [31:0] instr = '0, pc = '0;
    logic [4:0]  exc = '0, exc_new = '0;
    logic [68:0] payload = '0;
    int          pass = 0, total = 0;
    bit          started = 1'b0;
    st_t         mk, mr;

    always #5 clk = ~clk;

    pipe_stage_reg_if ik ();
    pipe_stage_reg_if ir ();
    assign {ik.en, ik.flush, ik.req, ik.instr_i, ik.pc_i, ik.bd_i, ik.exc_i, ik.exc_new_i, ik.payload_i} =
           {en, flush, req, instr, pc, bd, exc, exc_new, payload};
    assign {ir.en, ir.flush, ir.req, ir.instr_i, ir.pc_i, ir.bd_i, ir.exc_i, ir.exc_new_i, ir.payload_i} =
           {en, flush, req, instr, pc, bd, exc, exc_new, payload};

    pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1'b1)) dut_k (.clk(clk), .reset(reset), .bus(ik.slave));
    pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1'b0)) dut_r (.clk(clk), .reset(reset), .bus(ir.slave));

    function automatic st_t next_state(st_t s, bit keep);
        st_t n = s;
        if (reset || req) begin
            n = '0;
            n.pc = reset ? 32'h3000 : 32'h4180;
        end else if (flush) begin
            n = '0;
            n.pc = keep ? pc : 32'h3000;
            n.bd = keep ? bd : 1'b0;
        end else if (!en) begin
            n.cnt = (int'(s.cnt) + 1 > 255) ? 8'd255 : s.cnt + 8'd1;
        end else begin
            n = '{instr: instr, pc: pc, bd: bd, exc: (exc != 0) ? exc : exc_new,
                  payload: payload, valid: 1'b1, cnt: 8'd0};
        end
        return n;
    endfunction

    always @(posedge clk) begin
        mk = next_state(mk, 1'b1);
        mr = next_state(mr, 1'b0);
        if (reset) started = 1'b1;
    end

    function automatic st_t snap_k();
        return '{ik.instr_o, ik.pc_o, ik.bd_o, ik.exc_o, ik.payload_o, ik.valid_o, ik.stall_cnt_o};
    endfunction
    function automatic st_t snap_r();
        return '{ir.instr_o, ir.pc_o, ir.bd_o, ir.exc_o, ir.payload_o, ir.valid_o, ir.stall_cnt_o};
    endfunction

    always @(negedge clk)
        if (started) begin
            total++;
            if (snap_k() === mk) pass++;
            else $display("FAIL model_keep t=%0t got=%h want=%h", $time, snap_k(), mk);
            total++;
            if (snap_r() === mr) pass++;
            else $display("FAIL model_reset_pc t=%0t got=%h want=%h", $time, snap_r(), mr);
        end

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s got=%h want=%h", name, act, exp);
    endtask

    task automatic cyc(input logic e, f, q, input logic [31:0] i, p, input logic b,
                       input logic [4:0] x, xn, input logic [68:0] pl);
        {en, flush, req, instr, pc, bd, exc, exc_new, payload} = {e, f, q, i, p, b, x, xn, pl};
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("rst_pc", ik.pc_o, 32'h3000);
        chk("rst_valid", ik.valid_o, 0);
        chk("rst_cnt", ik.stall_cnt_o, 0);
        reset = 1'b0;
        cyc(1, 0, 0, 32'h3C01_1234, 32'h3004, 0, 0, 0, 69'h1_2345_6789_ABCD_EF01);
        chk("cap_instr", ik.instr_o, 32'h3C01_1234);
        chk("cap_pc", ik.pc_o, 32'h3004);
        chk("cap_valid", ik.valid_o, 1);
        chk("cap_payload", ik.payload_o, 69'h1_2345_6789_ABCD_EF01);
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 0, 0, 32'hDEAD_0000 + k, 32'h5000 + k, 1, 4, 12, 69'h1F_FFFF_FFFF_FFFF_FFFF);
            chk("stall_cnt", ik.stall_cnt_o, k);
            chk("stall_instr", ik.instr_o, 32'h3C01_1234);
        end
        cyc(1, 0, 0, 32'h8C22_0004, 32'h3008, 1, 0, 0, 69'h0_0000_0000_0000_00AA);
        chk("rel_instr", ik.instr_o, 32'h8C22_0004);
        chk("rel_cnt", ik.stall_cnt_o, 0);
        cyc(0, 1, 0, 32'h1234_5678, 32'h3010, 1, 4, 4, 69'h3);
        chk("flush_instr", ik.instr_o, 0);
        chk("flush_valid", ik.valid_o, 0);
        chk("flush_pc_keep", ik.pc_o, 32'h3010);
        chk("flush_bd_keep", ik.bd_o, 1);
        chk("flush_pc_rst", ir.pc_o, 32'h3000);
        chk("flush_bd_rst", ir.bd_o, 0);
        cyc(1, 0, 0, 32'h1, 32'h3014, 0, 4, 12, 69'h0);
        chk("exc_old_wins", ik.exc_o, 4);
        cyc(1, 0, 0, 32'h2, 32'h3018, 0, 0, 12, 69'h0);
        chk("exc_new", ik.exc_o, 12);
        cyc(1, 0, 0, 32'h3, 32'h301C, 0, 0, 0, 69'h0);
        chk("exc_none", ik.exc_o, 0);
        cyc(0, 1, 1, 32'h4, 32'h3020, 1, 5, 10, 69'h7);
        chk("req_pc", ik.pc_o, 32'h4180);
        chk("req_pc_r", ir.pc_o, 32'h4180);
        chk("req_instr", ik.instr_o, 0);
        chk("req_valid", ik.valid_o, 0);
        cyc(1, 0, 0, 32'h0000_000C, 32'h3024, 0, 0, 10, 69'h55);
        chk("post_req_pc", ik.pc_o, 32'h3024);
        chk("post_req_exc", ik.exc_o, 10);
        for (int k = 0; k < 260; k++) cyc(0, 0, 0, k, k, 0, 0, 0, 69'h0);
        chk("sat_cnt", ik.stall_cnt_o, 255);
        reset = 1'b1;
        cyc(0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 31, 31, '1);
        chk("mid_rst_cnt", ik.stall_cnt_o, 0);
        chk("mid_rst_pc", ik.pc_o, 32'h3000);
        chk("mid_rst_instr", ik.instr_o, 0);
        reset = 1'b0;
        cyc(1, 0, 0, 32'hAAAA_5555, 32'h3028, 1, 5, 0, '1);
        chk("final_payload", ik.payload_o, '1);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
